lsu_wb: RTL and testbench

Load/store unit with write-back. It sits between execute and the register file write port (`reg_wen`/`reg_waddr`/`reg_wdata`). It takes one memory instruction at a time and computes the effective address. It then runs a valid/ready transaction on the data-memory port. Stores get byte lane steering; load data is extracted and sign- or zero-extended, then written to the register file as a single-cycle write pulse.

---
 rtl/lsu_wb_pkg.sv | 36 +++
 rtl/lsu_wb_align.sv | 65 ++++++
 rtl/lsu_wb.sv | 166 ++++++++++++++++
 tb/tb_lsu_wb.sv | 250 +++++++++++++++++++++++++
 4 files changed

// File: rtl/lsu_wb_pkg.sv
// Shared widths, funct3 size codes and FSM state encoding for the load/store write-back unit.
package lsu_wb_pkg;

  localparam int CPU_WIDTH      = 64;
  localparam int REG_ADDR_WIDTH = 5;

  localparam logic [2:0] LS_B  = 3'b000;
  localparam logic [2:0] LS_H  = 3'b001;
  localparam logic [2:0] LS_W  = 3'b010;
  localparam logic [2:0] LS_D  = 3'b011;
  localparam logic [2:0] LS_BU = 3'b100;
  localparam logic [2:0] LS_HU = 3'b101;
  localparam logic [2:0] LS_WU = 3'b110;

  typedef enum logic [2:0] {
    LSU_IDLE = 3'd0,
    LSU_REQ  = 3'd1,
    LSU_WAIT = 3'd2,
    LSU_WB   = 3'd3,
    LSU_ERR  = 3'd4
  } lsu_state_e;

  // Byte-enable pattern for an access size before lane shifting.
  function automatic logic [7:0] size_mask(input logic [1:0] size);
    logic [7:0] m;
    case (size)
      2'b00:   m = 8'h01;
      2'b01:   m = 8'h03;
      2'b10:   m = 8'h0F;
      2'b11:   m = 8'hFF;
      default: m = 8'h00;
    endcase
    return m;
  endfunction

endpackage

// File: rtl/lsu_wb_align.sv
// Combinational lane logic: legality/alignment check and store steering for the offered op,
// plus load extraction and extension for the op already in flight.
module lsu_align
  import lsu_wb_pkg::*;
#(
  parameter int XLEN = CPU_WIDTH
) (
  input  logic            chk_store,
  input  logic [2:0]      chk_funct3,
  input  logic [2:0]      chk_off,
  input  logic [XLEN-1:0] st_data,
  input  logic [2:0]      ld_funct3,
  input  logic [2:0]      ld_off,
  input  logic [XLEN-1:0] ld_rdata,
  output logic [XLEN-1:0] st_wdata,
  output logic [7:0]      st_wmask,
  output logic [XLEN-1:0] ld_data,
  output logic            op_err
);

  logic            illegal_s;
  logic            misalign_s;
  logic [XLEN-1:0] shifted_s;

  assign st_wdata  = st_data << {chk_off, 3'b000};
  assign st_wmask  = size_mask(chk_funct3[1:0]) << chk_off;
  assign shifted_s = ld_rdata >> {ld_off, 3'b000};
  assign op_err    = illegal_s | misalign_s;

  // Illegal encodings and natural-alignment violations of the offered op.
  always_comb begin
    illegal_s  = 1'b0;
    misalign_s = 1'b0;
    if (chk_funct3 == 3'b111) begin
      illegal_s = 1'b1;
    end else if (chk_store && chk_funct3[2]) begin
      illegal_s = 1'b1;
    end else begin
      illegal_s = 1'b0;
    end
    case (chk_funct3[1:0])
      2'b00:   misalign_s = 1'b0;
      2'b01:   misalign_s = chk_off[0];
      2'b10:   misalign_s = |chk_off[1:0];
      2'b11:   misalign_s = |chk_off;
      default: misalign_s = 1'b0;
    endcase
  end

  // Truncate the lane-shifted read data to the access size and extend it.
  always_comb begin
    ld_data = {XLEN{1'b0}};
    case (ld_funct3)
      LS_B:    ld_data = {{(XLEN-8){shifted_s[7]}}, shifted_s[7:0]};
      LS_H:    ld_data = {{(XLEN-16){shifted_s[15]}}, shifted_s[15:0]};
      LS_W:    ld_data = {{(XLEN-32){shifted_s[31]}}, shifted_s[31:0]};
      LS_D:    ld_data = shifted_s;
      LS_BU:   ld_data = {{(XLEN-8){1'b0}}, shifted_s[7:0]};
      LS_HU:   ld_data = {{(XLEN-16){1'b0}}, shifted_s[15:0]};
      LS_WU:   ld_data = {{(XLEN-32){1'b0}}, shifted_s[31:0]};
      default: ld_data = {XLEN{1'b0}};
    endcase
  end

endmodule

// File: rtl/lsu_wb.sv
// Load/store unit: accepts one memory op, runs the data-memory handshake and
// returns load results to the register file as a one-cycle write pulse.
module lsu_wb
  import lsu_wb_pkg::*;
#(
  parameter int XLEN = CPU_WIDTH,
  parameter int AW   = REG_ADDR_WIDTH
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            req_valid,
  output logic            req_ready,
  input  logic            req_store,
  input  logic [2:0]      req_funct3,
  input  logic [XLEN-1:0] req_base,
  input  logic [31:0]     req_imm,
  input  logic [XLEN-1:0] req_wdata,
  input  logic [AW-1:0]   req_rd,
  output logic            mem_req_valid,
  input  logic            mem_req_ready,
  output logic            mem_we,
  output logic [XLEN-1:0] mem_addr,
  output logic [XLEN-1:0] mem_wdata,
  output logic [7:0]      mem_wmask,
  input  logic            mem_rvalid,
  input  logic [XLEN-1:0] mem_rdata,
  output logic            reg_wen,
  output logic [AW-1:0]   reg_waddr,
  output logic [XLEN-1:0] reg_wdata,
  output logic            misalign_err
);

  lsu_state_e      state_r;
  logic            req_ready_r;
  logic            mem_req_valid_r;
  logic            mem_we_r;
  logic [XLEN-1:0] mem_addr_r;
  logic [XLEN-1:0] mem_wdata_r;
  logic [7:0]      mem_wmask_r;
  logic            reg_wen_r;
  logic [AW-1:0]   reg_waddr_r;
  logic [XLEN-1:0] reg_wdata_r;
  logic            misalign_err_r;
  logic [2:0]      funct3_r;
  logic [2:0]      off_r;
  logic [AW-1:0]   rd_r;

  logic [XLEN-1:0] ea_s;
  logic [XLEN-1:0] st_wdata_s;
  logic [7:0]      st_wmask_s;
  logic [XLEN-1:0] ld_data_s;
  logic            op_err_s;

  assign ea_s = req_base + {{(XLEN-32){req_imm[31]}}, req_imm};

  lsu_align #(.XLEN(XLEN)) u_align (
    .chk_store  (req_store),
    .chk_funct3 (req_funct3),
    .chk_off    (ea_s[2:0]),
    .st_data    (req_wdata),
    .ld_funct3  (funct3_r),
    .ld_off     (off_r),
    .ld_rdata   (mem_rdata),
    .st_wdata   (st_wdata_s),
    .st_wmask   (st_wmask_s),
    .ld_data    (ld_data_s),
    .op_err     (op_err_s)
  );

  // Control FSM; every output is a register updated on the transition that needs it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r         <= LSU_IDLE;
      req_ready_r     <= 1'b1;
      mem_req_valid_r <= 1'b0;
      mem_we_r        <= 1'b0;
      mem_addr_r      <= {XLEN{1'b0}};
      mem_wdata_r     <= {XLEN{1'b0}};
      mem_wmask_r     <= 8'h00;
      reg_wen_r       <= 1'b0;
      reg_waddr_r     <= {AW{1'b0}};
      reg_wdata_r     <= {XLEN{1'b0}};
      misalign_err_r  <= 1'b0;
      funct3_r        <= 3'b000;
      off_r           <= 3'b000;
      rd_r            <= {AW{1'b0}};
    end else begin
      case (state_r)
        LSU_IDLE: begin
          if (req_valid) begin
            req_ready_r <= 1'b0;
            funct3_r    <= req_funct3;
            off_r       <= ea_s[2:0];
            rd_r        <= req_rd;
            if (op_err_s) begin
              state_r        <= LSU_ERR;
              misalign_err_r <= 1'b1;
            end else begin
              state_r         <= LSU_REQ;
              mem_req_valid_r <= 1'b1;
              mem_we_r        <= req_store;
              mem_addr_r      <= {ea_s[XLEN-1:3], 3'b000};
              mem_wdata_r     <= req_store ? st_wdata_s : {XLEN{1'b0}};
              mem_wmask_r     <= req_store ? st_wmask_s : 8'h00;
            end
          end else begin
            state_r <= LSU_IDLE;
          end
        end
        LSU_REQ: begin
          if (mem_req_ready) begin
            mem_req_valid_r <= 1'b0;
            if (mem_we_r) begin
              state_r     <= LSU_IDLE;
              req_ready_r <= 1'b1;
            end else begin
              state_r <= LSU_WAIT;
            end
          end else begin
            state_r <= LSU_REQ;
          end
        end
        LSU_WAIT: begin
          // Writes to x0 still finish the read but never pulse the write port.
          if (mem_rvalid) begin
            state_r     <= LSU_WB;
            reg_wdata_r <= ld_data_s;
            reg_waddr_r <= rd_r;
            reg_wen_r   <= (rd_r != {AW{1'b0}});
          end else begin
            state_r <= LSU_WAIT;
          end
        end
        LSU_WB: begin
          state_r     <= LSU_IDLE;
          reg_wen_r   <= 1'b0;
          req_ready_r <= 1'b1;
        end
        LSU_ERR: begin
          state_r        <= LSU_IDLE;
          misalign_err_r <= 1'b0;
          req_ready_r    <= 1'b1;
        end
        default: begin
          state_r         <= LSU_IDLE;
          req_ready_r     <= 1'b1;
          mem_req_valid_r <= 1'b0;
          reg_wen_r       <= 1'b0;
          misalign_err_r  <= 1'b0;
        end
      endcase
    end
  end

  assign req_ready     = req_ready_r;
  assign mem_req_valid = mem_req_valid_r;
  assign mem_we        = mem_we_r;
  assign mem_addr      = mem_addr_r;
  assign mem_wdata     = mem_wdata_r;
  assign mem_wmask     = mem_wmask_r;
  assign reg_wen       = reg_wen_r;
  assign reg_waddr     = reg_waddr_r;
  assign reg_wdata     = reg_wdata_r;
  assign misalign_err  = misalign_err_r;

endmodule

// File: tb/tb_lsu_wb.sv
// Directed bench for lsu_wb: stores, loads with extension, stalls, errors, x0 loads,
// back-to-back ops and reset during an outstanding read.
module tb_lsu_wb;
  import lsu_wb_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_valid, req_ready, req_store;
  logic [2:0]  req_funct3;
  logic [63:0] req_base, req_wdata;
  logic [31:0] req_imm;
  logic [4:0]  req_rd;
  logic        mem_req_valid, mem_req_ready, mem_we;
  logic [63:0] mem_addr, mem_wdata;
  logic [7:0]  mem_wmask;
  logic        mem_rvalid;
  logic [63:0] mem_rdata;
  logic        reg_wen;
  logic [4:0]  reg_waddr;
  logic [63:0] reg_wdata;
  logic        misalign_err;

  int checks = 0;
  int errors = 0;

  lsu_wb #(.XLEN(64), .AW(5)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_store(req_store),
    .req_funct3(req_funct3), .req_base(req_base), .req_imm(req_imm),
    .req_wdata(req_wdata), .req_rd(req_rd),
    .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready), .mem_we(mem_we),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_wmask(mem_wmask),
    .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
    .reg_wen(reg_wen), .reg_waddr(reg_waddr), .reg_wdata(reg_wdata),
    .misalign_err(misalign_err)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: got=timeout exp=finish");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  task automatic check_reset(input string tag);
    check({tag, ".req_ready"}, req_ready, 1'b1);
    check({tag, ".mem_req_valid"}, mem_req_valid, 1'b0);
    check({tag, ".mem_we"}, mem_we, 1'b0);
    check({tag, ".mem_addr"}, mem_addr, 64'h0);
    check({tag, ".mem_wdata"}, mem_wdata, 64'h0);
    check({tag, ".mem_wmask"}, mem_wmask, 8'h00);
    check({tag, ".reg_wen"}, reg_wen, 1'b0);
    check({tag, ".reg_waddr"}, reg_waddr, 5'd0);
    check({tag, ".reg_wdata"}, reg_wdata, 64'h0);
    check({tag, ".misalign_err"}, misalign_err, 1'b0);
  endtask

  task automatic drive_req(input logic st, input logic [2:0] f3, input logic [63:0] base,
                           input logic [31:0] imm, input logic [63:0] wd, input logic [4:0] rd);
    req_valid  = 1'b1;
    req_store  = st;
    req_funct3 = f3;
    req_base   = base;
    req_imm    = imm;
    req_wdata  = wd;
    req_rd     = rd;
  endtask

  task automatic do_store(input string tag, input logic [2:0] f3, input logic [63:0] base,
                          input logic [31:0] imm, input logic [63:0] wd,
                          input logic [63:0] exp_addr, input logic [7:0] exp_mask,
                          input logic [63:0] exp_wdata);
    check({tag, ".ready0"}, req_ready, 1'b1);
    drive_req(1'b1, f3, base, imm, wd, 5'd0);
    mem_req_ready = 1'b1;
    @(negedge clk);
    req_valid = 1'b0;
    check({tag, ".mem_req_valid"}, mem_req_valid, 1'b1);
    check({tag, ".mem_we"}, mem_we, 1'b1);
    check({tag, ".mem_addr"}, mem_addr, exp_addr);
    check({tag, ".mem_wmask"}, mem_wmask, exp_mask);
    check({tag, ".mem_wdata"}, mem_wdata, exp_wdata);
    check({tag, ".busy"}, req_ready, 1'b0);
    @(negedge clk);
    check({tag, ".ready2"}, req_ready, 1'b1);
    check({tag, ".req_drop"}, mem_req_valid, 1'b0);
    check({tag, ".no_wen"}, reg_wen, 1'b0);
  endtask

  task automatic do_load(input string tag, input logic [2:0] f3, input logic [63:0] base,
                         input logic [31:0] imm, input logic [4:0] rd, input logic [63:0] rdata,
                         input int rdy_dly, input int rv_dly, input logic [63:0] exp_addr,
                         input logic [63:0] exp_data, input logic exp_wen);
    check({tag, ".ready0"}, req_ready, 1'b1);
    drive_req(1'b0, f3, base, imm, 64'h0, rd);
    mem_req_ready = (rdy_dly == 0);
    @(negedge clk);
    req_valid = 1'b0;
    check({tag, ".mem_req_valid"}, mem_req_valid, 1'b1);
    check({tag, ".mem_we"}, mem_we, 1'b0);
    check({tag, ".mem_addr"}, mem_addr, exp_addr);
    check({tag, ".mem_wmask"}, mem_wmask, 8'h00);
    for (int i = 0; i < rdy_dly; i++) begin
      @(negedge clk);
      check({tag, ".stall_valid"}, mem_req_valid, 1'b1);
      check({tag, ".stall_addr"}, mem_addr, exp_addr);
      check({tag, ".stall_we"}, mem_we, 1'b0);
    end
    mem_req_ready = 1'b1;
    @(negedge clk);
    mem_req_ready = 1'b0;
    check({tag, ".wait_valid"}, mem_req_valid, 1'b0);
    for (int i = 1; i < rv_dly; i++) begin
      @(negedge clk);
      check({tag, ".wait_wen"}, reg_wen, 1'b0);
    end
    mem_rvalid = 1'b1;
    mem_rdata  = rdata;
    @(negedge clk);
    mem_rvalid = 1'b0;
    mem_rdata  = 64'h5A5A_5A5A_5A5A_5A5A;
    check({tag, ".wen"}, reg_wen, exp_wen);
    if (exp_wen) begin
      check({tag, ".waddr"}, reg_waddr, rd);
      check({tag, ".wdata"}, reg_wdata, exp_data);
    end
    check({tag, ".busy_wb"}, req_ready, 1'b0);
    @(negedge clk);
    check({tag, ".wen_off"}, reg_wen, 1'b0);
    check({tag, ".ready_end"}, req_ready, 1'b1);
  endtask

  task automatic do_err(input string tag, input logic st, input logic [2:0] f3,
                        input logic [63:0] base, input logic [31:0] imm);
    check({tag, ".ready0"}, req_ready, 1'b1);
    drive_req(st, f3, base, imm, 64'hFFFF, 5'd3);
    mem_req_ready = 1'b1;
    @(negedge clk);
    req_valid = 1'b0;
    check({tag, ".err"}, misalign_err, 1'b1);
    check({tag, ".no_req"}, mem_req_valid, 1'b0);
    check({tag, ".busy"}, req_ready, 1'b0);
    @(negedge clk);
    check({tag, ".err_off"}, misalign_err, 1'b0);
    check({tag, ".no_req2"}, mem_req_valid, 1'b0);
    check({tag, ".no_wen"}, reg_wen, 1'b0);
    check({tag, ".ready2"}, req_ready, 1'b1);
  endtask

  initial begin
    req_valid = 1'b0; req_store = 1'b0; req_funct3 = 3'b000; req_base = 64'h0;
    req_imm = 32'h0; req_wdata = 64'h0; req_rd = 5'd0;
    mem_req_ready = 1'b0; mem_rvalid = 1'b0; mem_rdata = 64'h0;
    repeat (3) @(negedge clk);
    check_reset("rst");
    rst_n = 1'b1;
    @(negedge clk);

    do_store("sb",  LS_B, 64'h1000, 32'd3, 64'hAB, 64'h1000, 8'h08, 64'hAB00_0000);
    do_store("sh",  LS_H, 64'h1000, 32'd2, 64'h1234, 64'h1000, 8'h0C, 64'h1234_0000);
    do_store("sw",  LS_W, 64'h1000, 32'd4, 64'hDEAD_BEEF, 64'h1000, 8'hF0, 64'hDEAD_BEEF_0000_0000);
    do_store("sd",  LS_D, 64'h5000, 32'hFFFF_FFF0, 64'h0123_4567_89AB_CDEF, 64'h4FF0, 8'hFF,
             64'h0123_4567_89AB_CDEF);
    do_store("sb7", LS_B, 64'h1000, 32'd7, 64'h5A, 64'h1000, 8'h80, 64'h5A00_0000_0000_0000);

    do_load("lb",  LS_B,  64'h2000, 32'd5, 5'd7, 64'h0000_80FF_0000_0000, 0, 1, 64'h2000,
            64'hFFFF_FFFF_FFFF_FF80, 1'b1);
    do_load("lbu", LS_BU, 64'h2000, 32'd5, 5'd7, 64'h0000_80FF_0000_0000, 0, 1, 64'h2000,
            64'h80, 1'b1);
    do_load("ld",  LS_D,  64'h3000, 32'hFFFF_FFF8, 5'd9, 64'h0123_4567_89AB_CDEF, 3, 4, 64'h2FF8,
            64'h0123_4567_89AB_CDEF, 1'b1);
    do_load("lh",  LS_H,  64'h4000, 32'd6, 5'd3, 64'hBEEF_0000_0000_0000, 0, 2, 64'h4000,
            64'hFFFF_FFFF_FFFF_BEEF, 1'b1);
    do_load("lhu", LS_HU, 64'h4000, 32'd6, 5'd3, 64'hBEEF_0000_0000_0000, 1, 1, 64'h4000,
            64'hBEEF, 1'b1);
    do_load("lw",  LS_W,  64'h4000, 32'd4, 5'd31, 64'h8000_0001_1111_2222, 0, 1, 64'h4000,
            64'hFFFF_FFFF_8000_0001, 1'b1);
    do_load("lwu", LS_WU, 64'h4000, 32'd4, 5'd31, 64'h8000_0001_1111_2222, 0, 1, 64'h4000,
            64'h8000_0001, 1'b1);
    do_load("lw_x0", LS_W, 64'h6000, 32'd0, 5'd0, 64'h7777_7777_7777_7777, 0, 1, 64'h6000,
            64'h0, 1'b0);

    do_err("lw_mis",  1'b0, LS_W,   64'h1000, 32'd2);
    do_err("s_100",   1'b1, 3'b100, 64'h1000, 32'd0);
    do_err("l_111",   1'b0, 3'b111, 64'h1000, 32'd0);
    do_err("lh_odd",  1'b0, LS_H,   64'h1001, 32'd0);
    do_err("sd_off4", 1'b1, LS_D,   64'h1004, 32'd0);

    // Store then load with req_valid held high throughout.
    drive_req(1'b1, LS_B, 64'h1000, 32'd1, 64'h11, 5'd0);
    mem_req_ready = 1'b1;
    @(negedge clk);
    drive_req(1'b0, LS_D, 64'h8000, 32'd8, 64'h0, 5'd12);
    check("b2b.c1_busy", req_ready, 1'b0);
    check("b2b.c1_we", mem_we, 1'b1);
    @(negedge clk);
    check("b2b.c2_ready", req_ready, 1'b1);
    check("b2b.c2_idle", mem_req_valid, 1'b0);
    @(negedge clk);
    req_valid = 1'b0;
    check("b2b.c3_req", mem_req_valid, 1'b1);
    check("b2b.c3_we", mem_we, 1'b0);
    check("b2b.c3_addr", mem_addr, 64'h8008);
    @(negedge clk);
    mem_req_ready = 1'b0;
    mem_rvalid = 1'b1;
    mem_rdata  = 64'hCAFE_F00D_1234_5678;
    @(negedge clk);
    mem_rvalid = 1'b0;
    check("b2b.wen", reg_wen, 1'b1);
    check("b2b.waddr", reg_waddr, 5'd12);
    check("b2b.wdata", reg_wdata, 64'hCAFE_F00D_1234_5678);
    @(negedge clk);
    check("b2b.ready_end", req_ready, 1'b1);

    // Reset while a read is outstanding, then a late rvalid.
    drive_req(1'b0, LS_D, 64'h7000, 32'd0, 64'h0, 5'd4);
    mem_req_ready = 1'b1;
    @(negedge clk);
    req_valid = 1'b0;
    @(negedge clk);
    mem_req_ready = 1'b0;
    rst_n = 1'b0;
    @(negedge clk);
    check_reset("rst_mid");
    rst_n = 1'b1;
    mem_rvalid = 1'b1;
    mem_rdata  = 64'h1111_2222_3333_4444;
    @(negedge clk);
    mem_rvalid = 1'b0;
    check_reset("rst_late_rv");
    @(negedge clk);
    check("rst.no_wen", reg_wen, 1'b0);
    do_load("post_rst", LS_W, 64'h9000, 32'd0, 5'd5, 64'h0000_0000_7FFF_FFFF, 0, 1, 64'h9000,
            64'h7FFF_FFFF, 1'b1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
